// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package clk_div_pkg;

    // Upper bound on the channel count the divider is built for.
    localparam int MAX_CH = 16;

    // Divisor storage width inside the config struct; CNT_W must not exceed it.
    localparam int MAX_DIV_W = 32;

    // Output behaviour of a channel.
    typedef enum logic {
        MODE_TOGGLE = 1'b0,  // clk_out inverts on each event, 50 % duty
        MODE_TICK   = 1'b1   // clk_out is a one-cycle pulse after each event
    } mode_e;

    // Per-channel configuration, held both as the active and the shadow copy.
    typedef struct packed {
        logic [MAX_DIV_W-1:0] div;
        mode_e                mode;
        logic                 en;
    } ch_cfg_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active and shadow configuration, apply logic.
// The shadow copy only becomes active at the channel's terminal count
// (or immediately when the channel is disabled), so clk_out never glitches.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 24,
    parameter int DEF_DIV = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_mode,
    input  logic             cfg_en,
    output logic             busy,
    output logic             clk_out
);

    logic [CNT_W-1:0] cnt;
    ch_cfg_t          act;
    ch_cfg_t          shadow;
    logic             evt;

    // Terminal count of an enabled channel.
    assign evt = act.en && (32'(cnt) == (act.div - 32'd1));

    // Counter, output and configuration update; sync beats apply beats normal counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            busy    <= 1'b0;
            act     <= '{div: 32'(DEF_DIV), mode: MODE_TOGGLE, en: 1'b1};
            shadow  <= '{div: 32'(DEF_DIV), mode: MODE_TOGGLE, en: 1'b1};
        end else if (sync) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            if (busy) begin
                act  <= shadow;
                busy <= 1'b0;
            end
        end else if (busy && (evt || !act.en)) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            act     <= shadow;
            busy    <= 1'b0;
        end else begin
            if (cfg_we) begin
                shadow.div  <= (cfg_div == '0) ? 32'd1 : 32'(cfg_div);
                shadow.mode <= mode_e'(cfg_mode);
                shadow.en   <= cfg_en;
                busy        <= 1'b1;
            end
            if (!act.en) begin
                cnt     <= '0;
                clk_out <= 1'b0;
            end else if (evt) begin
                cnt     <= '0;
                clk_out <= (act.mode == MODE_TICK) ? 1'b1 : ~clk_out;
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (act.mode == MODE_TICK) begin
                    clk_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider: NUM_CH independent divided clocks / ticks,
// each reprogrammable at runtime through a shadowed config port.
// Optional feature macro: CLK_DIV_SYNC_EN adds a 'sync' input that
// phase-aligns every channel and applies all pending updates.
//
// Config handshake: a request transfers on a rising edge where
// cfg_valid && cfg_ready. cfg_ready is low while the addressed channel
// still has an update pending (and while sync is high); an out-of-range
// cfg_ch is always ready and the request is dropped.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int CNT_W   = 24,
    parameter  int DEF_DIV = 5,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    input  logic              cfg_en,
`ifdef CLK_DIV_SYNC_EN
    input  logic              sync,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] busy
);

    logic sync_i;
    logic ch_in_range;

`ifdef CLK_DIV_SYNC_EN
    assign sync_i = sync;
`else
    assign sync_i = 1'b0;
`endif

    assign ch_in_range = (32'(cfg_ch) < NUM_CH);

    // Ready follows the addressed channel's pending flag; sync blocks acceptance.
    always_comb begin
        cfg_ready = 1'b1;
        if (sync_i) begin
            cfg_ready = 1'b0;
        end else if (ch_in_range) begin
            cfg_ready = ~busy[cfg_ch];
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic we;

        // Write strobe for this channel only.
        assign we = cfg_valid && cfg_ready && ch_in_range && (32'(cfg_ch) == i);

        clk_div_chan #(
            .CNT_W  (CNT_W),
            .DEF_DIV(DEF_DIV)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .sync    (sync_i),
            .cfg_we  (we),
            .cfg_div (cfg_div),
            .cfg_mode(cfg_mode),
            .cfg_en  (cfg_en),
            .busy    (busy[i]),
            .clk_out (clk_out[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios plus random
// config traffic, compared cycle by cycle against an arithmetic model.
module tb_clk_div_multi;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 24;
    localparam int DEF_DIV = 5;

    // ---------------- clock / reset ----------------
    logic              clk;
    logic              reset;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_mode;
    logic              cfg_en;
    logic              sync;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    clk_div_multi #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DEF_DIV(DEF_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_mode (cfg_mode),
        .cfg_en   (cfg_en),
`ifdef CLK_DIV_SYNC_EN
        .sync     (sync),
`endif
        .clk_out  (clk_out),
        .busy     (busy)
    );

    // ---------------- scoreboard ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [NUM_CH-1:0] exp_q[$];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each channel is described by its active settings and the number of
    // enabled edges since its phase last restarted (m_n). Outputs follow
    // from m_n by plain arithmetic.
    int m_div[NUM_CH];
    bit m_mode[NUM_CH];
    bit m_en[NUM_CH];
    int m_n[NUM_CH];
    bit m_busy[NUM_CH];
    int s_div[NUM_CH];
    bit s_mode[NUM_CH];
    bit s_en[NUM_CH];

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i] = DEF_DIV; m_mode[i] = 1'b0; m_en[i] = 1'b1;
            m_n[i] = 0; m_busy[i] = 1'b0;
            s_div[i] = DEF_DIV; s_mode[i] = 1'b0; s_en[i] = 1'b1;
        end
        exp_q.delete();
    endtask

    function automatic bit exp_ready();
        if (sync) return 1'b0;
        if (int'(cfg_ch) >= NUM_CH) return 1'b1;
        return !m_busy[cfg_ch];
    endfunction

    function automatic bit exp_bit(int i);
        if (!m_en[i]) return 1'b0;
        if (m_mode[i]) return (m_n[i] > 0) && (m_n[i] % m_div[i] == 0);
        return ((m_n[i] / m_div[i]) % 2) == 1;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_busy();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic apply_shadow(int i);
        m_div[i] = s_div[i]; m_mode[i] = s_mode[i]; m_en[i] = s_en[i];
        m_busy[i] = 1'b0; m_n[i] = 0;
    endtask

    // Advance the model by one rising edge using the inputs held for it.
    task automatic model_edge();
        bit rdy;
        logic [NUM_CH-1:0] v;
        rdy = exp_ready();
        for (int i = 0; i < NUM_CH; i++) begin
            bit evt;
            evt = m_en[i] && ((m_n[i] + 1) % m_div[i] == 0);
            if (sync) begin
                if (m_busy[i]) apply_shadow(i);
                m_n[i] = 0;
            end else if (m_busy[i] && (!m_en[i] || evt)) begin
                apply_shadow(i);
            end else begin
                if (cfg_valid && rdy && int'(cfg_ch) == i) begin
                    s_div[i] = (cfg_div == 0) ? 1 : int'(cfg_div);
                    s_mode[i] = cfg_mode; s_en[i] = cfg_en;
                    m_busy[i] = 1'b1;
                end
                m_n[i] = m_en[i] ? m_n[i] + 1 : 0;
            end
            v[i] = exp_bit(i);
        end
        exp_q.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    // Entered just after a falling edge with inputs already driven.
    task automatic cycle();
        logic [NUM_CH-1:0] e;
        #1;
        check("cfg_ready", cfg_ready, exp_ready());
        @(posedge clk);
        model_edge();
        #1;
        e = exp_q.pop_front();
        check("clk_out", clk_out, e);
        check("busy", busy, exp_busy());
        @(negedge clk);
    endtask

    task automatic idle(int n);
        cfg_valid = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic send_cfg(int ch, int div, bit mode, bit en);
        int waited;
        waited = 0;
        cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_div = CNT_W'(div);
        cfg_mode = mode; cfg_en = en;
        while (!exp_ready() && waited < 64) begin
            cycle();
            waited++;
        end
        check("cfg_wait_bound", 32'(waited < 64), 32'd1);
        cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_applied(int ch);
        int waited;
        waited = 0;
        while (m_busy[ch] && waited < 64) begin
            cycle();
            waited++;
        end
        check("apply_bound", 32'(waited < 64), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        cfg_mode = 1'b0; cfg_en = 1'b0; sync = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check("rst_clk_out", clk_out, '0);
        check("rst_busy", busy, '0);
        check("rst_ready", cfg_ready, 1);
        reset = 1'b0;

        // Defaults: toggle every DEF_DIV edges on every channel.
        idle(25);

        // ch1 -> div 3 tick, issued mid-period.
        send_cfg(1, 3, 1'b1, 1'b1);
        check("ch1_busy_after_accept", busy[1], 1);
        wait_applied(1);
        idle(12);

        // Back-to-back to ch0, ch2 accepted in between.
        send_cfg(0, 7, 1'b0, 1'b1);
        send_cfg(2, 2, 1'b0, 1'b1);
        send_cfg(0, 4, 1'b1, 1'b1);
        wait_applied(0);
        idle(16);

        // Divisor 0 and 1 in both modes.
        send_cfg(0, 0, 1'b0, 1'b1);
        send_cfg(1, 1, 1'b1, 1'b1);
        send_cfg(2, 0, 1'b1, 1'b1);
        send_cfg(3, 1, 1'b0, 1'b1);
        for (int i = 0; i < NUM_CH; i++) wait_applied(i);
        idle(8);

        // Disable ch3, then re-enable with div 4.
        send_cfg(3, 6, 1'b0, 1'b0);
        wait_applied(3);
        idle(6);
        send_cfg(3, 4, 1'b0, 1'b1);
        wait_applied(3);
        idle(12);

        // Random config traffic; valid is not held, dropped requests are legal.
        for (int k = 0; k < 400; k++) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = 2'($urandom_range(0, NUM_CH - 1));
            cfg_div   = CNT_W'($urandom_range(0, 7));
            cfg_mode  = 1'($urandom_range(0, 1));
            cfg_en    = ($urandom_range(0, 5) != 0);
            cycle();
        end
        cfg_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) wait_applied(i);

`ifdef CLK_DIV_SYNC_EN
        // Divisors 3/4/5/6 in toggle mode, then phase-align with sync.
        for (int i = 0; i < NUM_CH; i++) begin
            send_cfg(i, 3 + i, 1'b0, 1'b1);
            wait_applied(i);
        end
        idle(7);
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        check("sync_clk_out", clk_out, '0);
        idle(14);
        // Sync with a pending update applies it at once.
        send_cfg(2, 2, 1'b1, 1'b1);
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        check("sync_busy", busy, '0);
        idle(10);
`endif

        // Reset mid-run with an update pending.
        send_cfg(0, 9, 1'b0, 1'b1);
        idle(2);
        reset = 1'b1;
        #1;
        check("midrst_clk_out", clk_out, '0);
        check("midrst_busy", busy, '0);
        check("midrst_ready", cfg_ready, 1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(22);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel clock divider: derives NUM_CH independent low-rate clock/tick outputs from the single system clock. Each channel's divisor, mode and enable can be reprogrammed at runtime through a valid/ready config port. Updates are shadowed and applied only at a channel's terminal count, so outputs never glitch. It replaces the fixed-ratio divider and feeds display-refresh, debounce and blink logic from one block.

## Interface
- NUM_CH, 4, number of output channels (1..16)
- CNT_W, 24, divisor/counter width
- DEF_DIV, 5, reset divisor for every channel
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- cfg_valid  input  1  config request
- cfg_ready  output  1  config accepted when cfg_valid & cfg_ready
- cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel
- cfg_div  input  CNT_W  new divisor D
- cfg_mode  input  1  0 = toggle (50 % duty), 1 = tick (1-cycle pulse)
- cfg_en  input  1  channel enable
- clk_out  output  NUM_CH  per-channel divided clock/tick, registered
- busy  output  NUM_CH  per-channel update pending

## Operation
- Each channel: counter 0..D-1, active div/mode/en, shadow div/mode/en plus pending flag.
- Event: enabled channel with counter == D-1; counter wraps to 0, otherwise increments.
- Toggle mode: clk_out inverts on each event → period 2·D clk, 50 % duty.
- Tick mode: clk_out high for exactly the event cycle's successor (one cycle), else 0 → period D.
- D = 1: toggle → clk_out inverts every cycle; tick → clk_out constantly 1.
- cfg_div = 0 is stored as 1.
- Disabled channel: counter held at 0, clk_out 0.
- cfg_ready = ~busy[cfg_ch]; cfg_ch ≥ NUM_CH → cfg_ready = 1 and request is dropped.
- Accepted request captured in shadow, busy[ch] set.
- Apply rule: busy channel applies shadow at its next event edge, or on the next edge if currently disabled. Apply edge: counter ← 0, clk_out ← 0, active ← shadow, busy ← 0. Phase restarts from the apply edge.
- Channels fully independent; simultaneous events on several channels all handled in the same cycle.
- Reset: counters 0, clk_out all 0, div = DEF_DIV, mode toggle, en 1, busy 0, cfg_ready 1.

## Timing
- clk_out changes only on clk rising edge; no combinational path from inputs to clk_out.
- Counter reaches D-1 in cycle n → clk_out updated at edge ending cycle n.
- From reset release with D: first toggle D cycles after the first active edge.
- Config accepted at edge t → busy visible after t; apply no earlier than edge t+1.
- Worst-case apply latency = active D cycles.
- Second request to a busy channel stalls (cfg_ready 0) until apply edge + 0 (ready same cycle busy clears).
- Reset asserted mid-operation: all state cleared immediately, pending updates discarded.

## Configuration
- CLK_DIV_SYNC_EN defined: adds input sync (1 bit, after cfg_en). sync high at an edge: every channel counter ← 0, clk_out ← 0, pending shadows applied, busy cleared — phase-aligns all channels. sync takes priority over events and config acceptance in that cycle (cfg_ready forced 0 while sync high).
- Undefined: no sync port; channels align only via reset.

## Structure
- clk_div_pkg: mode constants (MODE_TOGGLE = 0, MODE_TICK = 1), channel config struct type (div, mode, en), max-channel constant.
- Sub-module clk_div_chan: one channel (counter, active/shadow regs, apply logic); top instantiates NUM_CH via generate and muxes cfg_ready/decodes cfg_ch.

## Test plan
- Reset release, defaults (DEF_DIV 5) → every clk_out toggles every 5 cycles, period 10, 50 % duty.
- Program ch1 div 3 tick mode mid-period → busy[1] high until next ch1 event, then 1-cycle pulse every 3 cycles, first pulse 3 cycles after apply.
- Two back-to-back requests to ch0 → second stalls with cfg_ready 0 until first applies; ch2 request in same window accepted immediately.
- cfg_div 0 and 1 in toggle and tick → clk_out toggles every cycle / constant 1.
- Disable ch3 (cfg_en 0) → applied next edge, clk_out[3] held 0; re-enable div 4 → first toggle 4 cycles later.
- With CLK_DIV_SYNC_EN, divisors 3/4/5/6, pulse sync → all counters and clk_out 0 same edge, then toggle at cycles 3/4/5/6; reset asserted mid-run clears busy and outputs immediately.
